note_source_arbiter: RTL
========================

Name: note_source_arbiter

Overview:
- Shares the single note bus (code/press/release) between three note sources: PS/2 keyboard (src 0), microphone pitch detector (src 1), and auto-play sequencer (src 2).
- Drives the audio, LED, seven-segment and VGA units through one arbitrated stream.
- Owns at most one sounding note at a time, with fixed priority and preemption.
- Guarantees every emitted press is eventually matched by a release, including stuck-note timeout and source disable.

Parameters:
- CODE_W, 8, key code width.
- TIMEOUT_CYCLES, 200000000, max hold time before a forced release (2 s at 100 MHz).
- TO_W, 28, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK100MHZ, in, 1, system clock.
- CPU_RESETN, in, 1, reset, asynchronous, active-low.
- src_en, in, 3, per-source enable from switches, bit i = src i.
- src_code, in, 3*CODE_W, source i code at bits [i*CODE_W +: CODE_W].
- src_press, in, 3, one-cycle press strobe per source.
- src_release, in, 3, one-cycle release strobe per source.
- key_code, out, CODE_W, arbitrated code; stable from press until release.
- key_valid, out, 1, one-cycle press strobe.
- key_released, out, 1, one-cycle release strobe.
- owner, out, 2, current owning source; 2'b11 = none.
- note_active, out, 1, high from the press strobe through the cycle before the release strobe.

Behaviour:
- Reset values: key_code=0, key_valid=0, key_released=0, owner=2'b11, note_active=0, timer=0, state IDLE. Reset mid-note emits no release.
- Priority: src2 > src0 > src1. A strobe from a source with src_en[i]=0 is ignored and not counted.
- All outputs are registered. An input accepted in cycle N produces its output strobe in cycle N+1.
- States:
  - IDLE:
    - Pick the highest-priority enabled press. Latch its code and owner; key_valid=1; note_active=1; go to HOLD.
    - Presses from other sources in the same cycle are dropped.
  - HOLD:
    - Owner release with code==key_code: key_released=1, note_active=0, owner=11, go to IDLE.
    - Owner release with a mismatched code: ignored.
    - Owner press with a new code (legato; takes precedence over a same-cycle owner release): key_released=1 for the old code, store the new code in pending, go to SWAP.
    - Press from a strictly higher-priority enabled source (preempt): same as legato, and pending owner = that source.
    - Press from a lower-priority source: dropped.
    - A higher-priority source pressing in the same cycle as an owner legato wins; the owner's press is dropped.
    - Owner's src_en goes low: forced release next cycle, go to IDLE.
    - Timer reaches TIMEOUT_CYCLES-1: forced release, go to IDLE.
  - SWAP (exactly 1 cycle):
    - key_code=pending, owner=pending owner, key_valid=1, note_active=1, timer=0, go to HOLD.
    - All input strobes arriving this cycle are dropped.
- key_valid and key_released are never high in the same cycle.
- Timer:
  - Cleared on every emitted press; increments in HOLD.
  - An owner press of the same code as key_code (repeat) only clears the timer and emits nothing.
- Forced release leaves key_code unchanged; only key_released pulses.

Optional Feature:
- Macro: NOTE_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt[7:0], reset 0.
  - Increments by 1 per cycle in which at least one enabled press is dropped, saturating at 255.
  - Adds output timeout_flag, set on forced timeout release, cleared only by reset.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- PS/2 press code 0x1C at cycle 10, release 0x1C at cycle 50 -> key_valid at 11 with key_code=0x1C and owner=00; key_released at 51; owner=11 at 51.
- Mic holds 0x23 and auto presses 0x2B -> one-cycle key_released with key_code=0x23, next cycle key_valid with key_code=0x2B and owner=10. A later mic release of 0x23 produces no output.
- Auto holds 0x2B, PS/2 presses 0x1C -> no output change; drop_cnt=1 (macro on).
- PS/2 holds 0x1C, then src_en[0] is cleared -> key_released next cycle, note_active=0, owner=11.
- TIMEOUT_CYCLES=100, mic holds 0x15 with no release -> key_released exactly 100 cycles after key_valid; timeout_flag=1 (macro on).
- Simultaneous presses src0=0x1C, src1=0x23, src2=0x2B in IDLE -> key_code=0x2B, owner=10; drop_cnt=1. Assert CPU_RESETN low mid-hold -> all outputs zero immediately, owner=11.

Source files
------------

// File: rtl/note_source_arbiter.sv
// Arbitrates three note sources onto one press/release bus with fixed priority
// (src2 > src0 > src1), preemption, legato and stuck-note timeout.
// Optional NOTE_ARB_DROP_CNT_EN adds the drop_cnt and timeout_flag outputs.
module note_source_arbiter #(
    parameter int CODE_W         = 8,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int TO_W           = 28
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic [2:0]            src_en,
    input  logic [3*CODE_W-1:0]   src_code,
    input  logic [2:0]            src_press,
    input  logic [2:0]            src_release,
    output logic [CODE_W-1:0]     key_code,
    output logic                  key_valid,
    output logic                  key_released,
    output logic [1:0]            owner,
    output logic                  note_active
`ifdef NOTE_ARB_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt,
    output logic                  timeout_flag
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'b11;

    function automatic logic [1:0] pick(input logic [2:0] req);
        if (req[2])      return 2'd2;
        else if (req[0]) return 2'd0;
        else             return 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Sources that may preempt the given owner.
    function automatic logic [2:0] higher_than(input logic [1:0] src);
        case (src)
            2'd0:    return 3'b100;
            2'd1:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] code_of(input logic [3*CODE_W-1:0] codes,
                                                  input logic [1:0]          src);
        case (src)
            2'd0:    return codes[0 +: CODE_W];
            2'd1:    return codes[CODE_W +: CODE_W];
            default: return codes[2*CODE_W +: CODE_W];
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_released_q, key_released_d;
    logic [1:0]        owner_q, owner_d;
    logic              note_active_q, note_active_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d;
    logic [1:0]        pend_owner_q, pend_owner_d;

    logic [2:0]        en_press;
    logic [2:0]        en_rel;
    logic [2:0]        own_mask;
    logic [2:0]        hi_press;
    logic              own_en;
    logic              own_press;
    logic [CODE_W-1:0] own_code;
    logic              own_rel_match;
    logic              timeout_hit;
    logic              do_release;

    assign en_press      = src_press & src_en;
    assign en_rel        = src_release & src_en;
    assign own_mask      = onehot(owner_q);
    assign hi_press      = en_press & higher_than(owner_q);
    assign own_en        = |(own_mask & src_en);
    assign own_press     = |(own_mask & en_press);
    assign own_code      = code_of(src_code, owner_q);
    assign own_rel_match = (|(own_mask & en_rel)) && (own_code == key_code_q);
    assign timeout_hit   = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        key_code_d     = key_code_q;
        key_valid_d    = 1'b0;
        key_released_d = 1'b0;
        owner_d        = owner_q;
        note_active_d  = note_active_q;
        timer_d        = timer_q;
        pend_code_d    = pend_code_q;
        pend_owner_d   = pend_owner_q;
        do_release     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|en_press) begin
                    key_code_d    = code_of(src_code, pick(en_press));
                    owner_d       = pick(en_press);
                    key_valid_d   = 1'b1;
                    note_active_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (|hi_press) begin
                    key_released_d = 1'b1;
                    note_active_d  = 1'b0;
                    pend_code_d    = code_of(src_code, pick(hi_press));
                    pend_owner_d   = pick(hi_press);
                    state_d        = ST_SWAP;
                end else if (!own_en) begin
                    do_release = 1'b1;
                end else if (own_press && (own_code != key_code_q)) begin
                    key_released_d = 1'b1;
                    note_active_d  = 1'b0;
                    pend_code_d    = own_code;
                    pend_owner_d   = owner_q;
                    state_d        = ST_SWAP;
                end else if (own_press) begin
                    timer_d = '0;
                end else if (own_rel_match || timeout_hit) begin
                    do_release = 1'b1;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            ST_SWAP: begin
                key_code_d    = pend_code_q;
                owner_d       = pend_owner_q;
                key_valid_d   = 1'b1;
                note_active_d = 1'b1;
                timer_d       = '0;
                state_d       = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase

        // Forced and normal releases leave key_code untouched.
        if (do_release) begin
            key_released_d = 1'b1;
            note_active_d  = 1'b0;
            owner_d        = OWNER_NONE;
            timer_d        = '0;
            state_d        = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q        <= ST_IDLE;
            key_code_q     <= '0;
            key_valid_q    <= 1'b0;
            key_released_q <= 1'b0;
            owner_q        <= OWNER_NONE;
            note_active_q  <= 1'b0;
            timer_q        <= '0;
            pend_code_q    <= '0;
            pend_owner_q   <= OWNER_NONE;
        end else begin
            state_q        <= state_d;
            key_code_q     <= key_code_d;
            key_valid_q    <= key_valid_d;
            key_released_q <= key_released_d;
            owner_q        <= owner_d;
            note_active_q  <= note_active_d;
            timer_q        <= timer_d;
            pend_code_q    <= pend_code_d;
            pend_owner_q   <= pend_owner_d;
        end
    end

    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign key_released = key_released_q;
    assign owner        = owner_q;
    assign note_active  = note_active_q;

`ifdef NOTE_ARB_DROP_CNT_EN
    logic [2:0] accepted;
    logic       dropped;
    logic       timeout_fire;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       timeout_flag_q, timeout_flag_d;

    // The single press acted on this cycle; every other enabled press is a drop.
    always_comb begin
        accepted = 3'b000;
        case (state_q)
            ST_IDLE: accepted = (|en_press) ? onehot(pick(en_press)) : 3'b000;
            ST_HOLD: accepted = (|hi_press) ? onehot(pick(hi_press)) : (own_mask & en_press);
            default: accepted = 3'b000;
        endcase
    end

    assign dropped      = |(en_press & ~accepted);
    assign timeout_fire = (state_q == ST_HOLD) && !(|hi_press) && own_en && !own_press
                          && !own_rel_match && timeout_hit;

    always_comb begin
        drop_cnt_d     = drop_cnt_q;
        timeout_flag_d = timeout_flag_q | timeout_fire;
        if (dropped && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            drop_cnt_q     <= 8'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign timeout_flag = timeout_flag_q;
`endif

endmodule
